// File: rtl/btn_key_pkg.sv
// Shared constants and types for the push-button to Hack keyboard arbiter.
// Key codes follow the Hack keyboard map for the Basys3 buttons C, U, L, R, D.
package btn_key_pkg;

    localparam int unsigned NUM_KEYS = 5;
    localparam logic [15:0] KEY_NONE = 16'd0;
    localparam logic [15:0] KEY_CODE [NUM_KEYS] = '{16'd128, 16'd131, 16'd130, 16'd132, 16'd133};

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    // Buttons without a mapped key report no key rather than indexing past the table.
    function automatic logic [15:0] key_of(input logic [2:0] idx);
        return (32'(idx) < NUM_KEYS) ? KEY_CODE[idx] : KEY_NONE;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one search: scans req starting just after
// last_owner, wrapping at N_BTN-1, and returns the first asserted index.
module rr_pick #(
    parameter int unsigned N_BTN = 5,
    localparam int unsigned IW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic [N_BTN-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = last_owner;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            cand = (cand == IW'(N_BTN - 1)) ? '0 : cand + 1'b1;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/btn_key_arbiter.sv
// Grants the Hack keyboard register to one held button at a time (round-robin)
// and emits a valid/ready key-event stream; auto-repeat when BTN_KEY_REPEAT_EN is defined.
module btn_key_arbiter
    import btn_key_pkg::*;
#(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [15:0]      key_code,
    output logic             busy,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [15:0]      evt_code,
    output logic             evt_drop
);

    localparam int unsigned IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_owner;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          rpt_hit;
    logic          issue;
    logic [15:0]   issue_code;

    rr_pick #(
        .N_BTN(N_BTN)
    ) u_pick (
        .req       (btn_in),
        .last_owner(last_owner),
        .idx       (pick_idx),
        .any       (pick_any)
    );

`ifdef BTN_KEY_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW      = $clog2(RPT_MAX + 1);

    logic [CW-1:0] rpt_cnt;
    logic [CW-1:0] rpt_thr;
    logic          first_done;

    assign rpt_thr = first_done ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1);
    assign rpt_hit = (state == OWN) && btn_in[owner] && (rpt_cnt == rpt_thr);

    // Held at zero while idle so every grant starts a fresh delay.
    always_ff @(posedge clk) begin
        if (!reset_n || state == IDLE) begin
            rpt_cnt    <= '0;
            first_done <= 1'b0;
        end else if (state == OWN) begin
            if (rpt_hit) begin
                rpt_cnt    <= '0;
                first_done <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rpt_hit           = 1'b0;
`endif

    always_comb begin
        issue      = 1'b0;
        issue_code = KEY_NONE;
        if (state == IDLE && pick_any) begin
            issue      = 1'b1;
            issue_code = key_of(3'(pick_idx));
        end else if (rpt_hit) begin
            issue      = 1'b1;
            issue_code = key_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(N_BTN - 1);
            key_code   <= KEY_NONE;
            busy       <= 1'b0;
            evt_valid  <= 1'b0;
            evt_code   <= KEY_NONE;
            evt_drop   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner    <= pick_idx;
                        key_code <= issue_code;
                        busy     <= 1'b1;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (!btn_in[owner]) begin
                        key_code   <= KEY_NONE;
                        busy       <= 1'b0;
                        last_owner <= owner;
                        state      <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase

            // A pending event is never overwritten; a new one without room is lost.
            if (issue) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_code  <= issue_code;
                end else begin
                    evt_drop <= 1'b1;
                end
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule
